// File: rtl/divrem_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : divrem_seq_if
// Description : Request/response bundle between the M-extension dispatcher
//               (master) and the sequential divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface divrem_seq_if #(
  parameter int WIDTH = 32
);
  logic             ce_i;
  logic             flush_i;
  logic [WIDTH-1:0] rs1_i;
  logic [WIDTH-1:0] rs2_i;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;
  logic             ready_o;
  logic [1:0]       status_o;

  // Dispatcher side: issues operands and consumes results
  modport master (
    output ce_i, flush_i, rs1_i, rs2_i,
    input  quot_o, rem_o, ready_o, status_o
  );

  // Divider side
  modport slave (
    input  ce_i, flush_i, rs1_i, rs2_i,
    output quot_o, rem_o, ready_o, status_o
  );
endinterface
`default_nettype wire

// File: rtl/divrem_seq.sv
`default_nettype none
// ============================================================================
// Module      : divrem_seq
// Description : Multi-cycle unsigned restoring divider. One quotient bit per
//               clock; quotient and remainder are produced together.
//               Optional macro DIVREM_EARLY_OUT_EN: divide-by-zero and
//               dividend<divisor complete directly from capture.
// Revision    : 1.0 - initial release
// ============================================================================
module divrem_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic  clk_i,
  input  wire logic  rst_n_i,
  divrem_seq_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);

  // State codes double as the status_o encoding, so status comes straight
  // from the state register.
  typedef enum logic [1:0] {
    S_IDLE = 2'b11,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic [CNT_W-1:0] r_cnt;
  // Partial remainder: it always stays below the divisor, so WIDTH bits hold
  // it; the extra sign bit only exists in the trial subtraction below.
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_neg;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // One restoring step: shift in the next dividend bit, try subtracting D
  always_comb begin
    w_shift  = {r_r, r_q[WIDTH-1]};
    w_trial  = w_shift - {1'b0, r_d};
    w_neg    = w_trial[WIDTH];
    w_r_next = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_q_next = {r_q[WIDTH-2:0], ~w_neg};
  end

`ifdef DIVREM_EARLY_OUT_EN
  logic w_div_zero;
  logic w_early;

  // Operands whose result is known without iterating
  always_comb begin
    w_div_zero = (bus.rs2_i == '0);
    w_early    = w_div_zero || (bus.rs1_i < bus.rs2_i);
  end
`endif

  // Control FSM and datapath registers; all outputs are registered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_cnt     <= '0;
      r_r       <= '0;
      r_q       <= '0;
      r_d       <= '0;
    end else if (bus.flush_i) begin
      // Abort: results keep their previous values
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.ce_i) begin
            r_q   <= bus.rs1_i;
            r_d   <= bus.rs2_i;
            r_r   <= '0;
            r_cnt <= c_cnt_init;
`ifdef DIVREM_EARLY_OUT_EN
            if (w_early) begin
              r_state   <= S_DONE;
              r_ready   <= 1'b1;
              r_quot    <= w_div_zero ? '1 : '0;
              r_rem_out <= bus.rs1_i;
            end else begin
              r_state <= S_BUSY;
            end
`else
            r_state <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state   <= S_DONE;
            r_ready   <= 1'b1;
            r_quot    <= w_q_next;
            r_rem_out <= w_r_next;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.quot_o   = r_quot;
  assign bus.rem_o    = r_rem_out;
  assign bus.ready_o  = r_ready;
  assign bus.status_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_divrem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divrem_seq
// Description : Directed and randomized self-checking bench for divrem_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divrem_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  divrem_seq_if #(.WIDTH(32)) bus();

  divrem_seq #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure issue spacing
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIVREM_EARLY_OUT_EN
    if (b == 32'd0 || a < b) return 1;
`endif
    return 33;
  endfunction

  // Issue one operation, drop ce after capture, scramble operands during
  // BUSY, wait for ready (bounded) and return to IDLE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output int lat, output bit to);
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.flush_i = 1'b0;
    bus.ce_i    = 1'b1;
    @(posedge clk); #1;
    bus.ce_i  = 1'b0;
    bus.rs1_i = ~a;
    bus.rs2_i = ~b;
    lat = 1;
    to  = 1'b0;
    while (bus.ready_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.ready_o !== 1'b1) to = 1'b1;
    q = bus.quot_o;
    r = bus.rem_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.ce_i    = 1'b0;
    bus.flush_i = 1'b0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    #23;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.status_o !== 2'b11) begin bad++; $display("FAIL reset_status got=%b exp=11", bus.status_o); end
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
    total++; if (bus.quot_o !== 32'd0) begin bad++; $display("FAIL reset_quot got=%h exp=0", bus.quot_o); end
    total++; if (bus.rem_o !== 32'd0) begin bad++; $display("FAIL reset_rem got=%h exp=0", bus.rem_o); end
  endtask

  // 100 / 7 with ce held: full status trace and result
  task automatic test_basic();
    bus.rs1_i = 32'd100;
    bus.rs2_i = 32'd7;
    bus.ce_i  = 1'b1;
    total++; if (bus.status_o !== 2'b11) begin bad++; $display("FAIL basic_pre_status got=%b exp=11", bus.status_o); end
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.status_o !== 2'b01 || bus.ready_o !== 1'b0) begin
        bad++; $display("FAIL basic_busy cycle=%0d got status=%b ready=%b exp status=01 ready=0", k, bus.status_o, bus.ready_o);
      end
    end
    @(posedge clk); #1;
    total++; if (bus.status_o !== 2'b10) begin bad++; $display("FAIL basic_done_status got=%b exp=10", bus.status_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", bus.ready_o); end
    total++; if (bus.quot_o !== 32'd14) begin bad++; $display("FAIL basic_quot got=%0d exp=14", bus.quot_o); end
    total++; if (bus.rem_o !== 32'd2) begin bad++; $display("FAIL basic_rem got=%0d exp=2", bus.rem_o); end
    bus.ce_i = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.status_o !== 2'b11) begin bad++; $display("FAIL basic_post_status got=%b exp=11", bus.status_o); end
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL basic_ready_pulse got=%b exp=0", bus.ready_o); end
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    int n;
    bus.rs1_i = 32'hFFFF_FFFF;
    bus.rs2_i = 32'd1;
    bus.ce_i  = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    c1 = cyc;
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_first_timeout got ready=%b exp=1", bus.ready_o); end
    total++; if (bus.quot_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_first_quot got=%h exp=ffffffff", bus.quot_o); end
    total++; if (bus.rem_o !== 32'd0) begin bad++; $display("FAIL b2b_first_rem got=%h exp=0", bus.rem_o); end
    bus.rs2_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    c2 = cyc;
    bus.ce_i = 1'b0;
    total++; if (c2 - c1 !== 34) begin bad++; $display("FAIL b2b_spacing got=%0d exp=34", c2 - c1); end
    total++; if (bus.quot_o !== 32'd1) begin bad++; $display("FAIL b2b_second_quot got=%h exp=1", bus.quot_o); end
    total++; if (bus.rem_o !== 32'd0) begin bad++; $display("FAIL b2b_second_rem got=%h exp=0", bus.rem_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    logic [31:0] q;
    logic [31:0] r;
    int lat;
    bit to;
    do_op(32'd5, 32'd0, q, r, lat, to);
    total++; if (to) begin bad++; $display("FAIL divzero_timeout got=no ready exp=ready"); end
    total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divzero_quot got=%h exp=ffffffff", q); end
    total++; if (r !== 32'd5) begin bad++; $display("FAIL divzero_rem got=%h exp=5", r); end
    total++; if (lat !== exp_lat(32'd5, 32'd0)) begin bad++; $display("FAIL divzero_latency got=%0d exp=%0d", lat, exp_lat(32'd5, 32'd0)); end
  endtask

  task automatic test_flush();
    logic [31:0] q;
    logic [31:0] r;
    int lat;
    bit to;
    int seen;
    do_op(32'd50, 32'd7, q, r, lat, to);
    total++; if (q !== 32'd7 || r !== 32'd1) begin bad++; $display("FAIL flush_prior got q=%0d r=%0d exp q=7 r=1", q, r); end
    // Flush in the 10th BUSY cycle
    bus.rs1_i = 32'd1000; bus.rs2_i = 32'd3; bus.ce_i = 1'b1;
    @(posedge clk); #1;
    bus.ce_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    total++; if (bus.status_o !== 2'b11) begin bad++; $display("FAIL flush_status got=%b exp=11", bus.status_o); end
    total++; if (bus.quot_o !== 32'd7 || bus.rem_o !== 32'd1) begin bad++; $display("FAIL flush_hold got q=%0d r=%0d exp q=7 r=1", bus.quot_o, bus.rem_o); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.ready_o === 1'b1) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_ready got=%0d pulses exp=0", seen); end
    // Flush coinciding with the final BUSY step
    bus.ce_i = 1'b1;
    @(posedge clk); #1;
    bus.ce_i = 1'b0;
    repeat (31) begin @(posedge clk); #1; end
    total++; if (bus.status_o !== 2'b01) begin bad++; $display("FAIL flush_last_pre got=%b exp=01", bus.status_o); end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    total++; if (bus.status_o !== 2'b11 || bus.ready_o !== 1'b0) begin bad++; $display("FAIL flush_last got status=%b ready=%b exp status=11 ready=0", bus.status_o, bus.ready_o); end
    total++; if (bus.quot_o !== 32'd7 || bus.rem_o !== 32'd1) begin bad++; $display("FAIL flush_last_hold got q=%0d r=%0d exp q=7 r=1", bus.quot_o, bus.rem_o); end
    do_op(32'd1000, 32'd3, q, r, lat, to);
    total++; if (to || q !== 32'd333 || r !== 32'd1) begin bad++; $display("FAIL flush_after got q=%0d r=%0d to=%0d exp q=333 r=1", q, r, to); end
  endtask

  task automatic test_async_reset();
    logic [31:0] q;
    logic [31:0] r;
    int lat;
    bit to;
    bus.rs1_i = 32'd1000; bus.rs2_i = 32'd3; bus.ce_i = 1'b1;
    @(posedge clk); #1;
    bus.ce_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (bus.status_o !== 2'b11) begin bad++; $display("FAIL arst_status got=%b exp=11", bus.status_o); end
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b exp=0", bus.ready_o); end
    total++; if (bus.quot_o !== 32'd0 || bus.rem_o !== 32'd0) begin bad++; $display("FAIL arst_results got q=%h r=%h exp q=0 r=0", bus.quot_o, bus.rem_o); end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'd9, 32'd2, q, r, lat, to);
    total++; if (to || q !== 32'd4 || r !== 32'd1) begin bad++; $display("FAIL arst_after got q=%0d r=%0d to=%0d exp q=4 r=1", q, r, to); end
    total++; if (lat !== 33) begin bad++; $display("FAIL arst_after_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_random();
    logic [31:0] spec [6];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    bit to;
    spec[0] = 32'd0; spec[1] = 32'd1; spec[2] = 32'h8000_0000;
    spec[3] = 32'hFFFF_FFFF; spec[4] = 32'd3; spec[5] = 32'h7FFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      a = (i % 4 == 0) ? spec[$urandom_range(0, 5)] : $urandom;
      case (i % 5)
        0:       b = spec[$urandom_range(0, 5)];
        1:       b = $urandom_range(0, 255);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (b == 32'd0) begin eq = 32'hFFFF_FFFF; er = a; end
      else begin eq = a / b; er = a % b; end
      do_op(a, b, q, r, lat, to);
      total++;
      if (to || q !== eq || r !== er || lat !== exp_lat(a, b)) begin
        bad++;
        $display("FAIL random a=%h b=%h got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d", a, b, q, r, lat, eq, er, exp_lat(a, b));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
